// File: rtl/riscv_regfile_mp.sv
`default_nettype none
// ============================================================================
// riscv_regfile_mp : RISC-V integer register file with NRD combinational read
// ports, post-reset clear sweep and pending-write scoreboard.
// Optional macro RISCV_RF_BYPASS_EN enables write-to-read forwarding.
// Rev 1.0
// ============================================================================
module riscv_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                rf_ready_o,
  input  logic                rf_wr_en_i,
  input  logic [AW-1:0]       rf_wr_addr_i,
  input  logic [XLEN-1:0]     rf_wr_data_i,
  input  logic [NRD*AW-1:0]   rf_rd_addr_i,
  output logic [NRD*XLEN-1:0] rf_rd_data_o,
  output logic [NRD-1:0]      rf_rd_busy_o,
  input  logic                sb_set_en_i,
  input  logic [AW-1:0]       sb_set_addr_i
);

  localparam logic [0:0]    C_CLEAR = 1'b0;
  localparam logic [0:0]    C_RUN   = 1'b1;
  localparam logic [AW-1:0] C_LAST  = AW'(NREGS - 1);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];

  logic w_run;
  logic w_wr_acc;
  logic w_set_acc;

  assign w_run      = (state_q == C_RUN);
  assign w_wr_acc   = w_run && rf_wr_en_i && (rf_wr_addr_i != '0);
  assign w_set_acc  = w_run && sb_set_en_i && (sb_set_addr_i != '0);
  assign rf_ready_o = w_run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == C_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == C_LAST) begin
        state_d = C_RUN;
      end
    end
  end

  // Set is applied after clear so a re-issue in the writeback cycle stays pending.
  always_comb begin
    pend_d = pend_q;
    if (w_wr_acc) begin
      pend_d[rf_wr_addr_i] = 1'b0;
    end
    if (w_set_acc) begin
      pend_d[sb_set_addr_i] = 1'b1;
    end
    if (!w_run) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    mem_d = mem_q;
    if (!w_run) begin
      mem_d[cnt_q] = '0;
    end else if (w_wr_acc) begin
      mem_d[rf_wr_addr_i] = rf_wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C_CLEAR;
      cnt_q   <= AW'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage carries no reset; the sweep zeroes it while reads are masked.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_busy;
      logic            w_fwd;

      assign w_addr = rf_rd_addr_i[k*AW +: AW];
`ifdef RISCV_RF_BYPASS_EN
      assign w_fwd = w_wr_acc && (rf_wr_addr_i == w_addr);
`else
      assign w_fwd = 1'b0;
`endif

      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (w_run) begin
          if (w_fwd) begin
            w_data = rf_wr_data_i;
            w_busy = w_set_acc && (sb_set_addr_i == w_addr);
          end else begin
            if (w_addr != '0) begin
              w_data = mem_q[w_addr];
            end
            w_busy = pend_q[w_addr];
          end
        end
      end

      assign rf_rd_data_o[k*XLEN +: XLEN] = w_data;
      assign rf_rd_busy_o[k]              = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire
